// File: rtl/modexp_ctrl_pkg.sv
// Shared types and constants for the modular-exponentiation controller.
// Defaults must match the external Montgomery multiplier width.
package modexp_ctrl_pkg;

    localparam int unsigned WIDTH  = 1024;
    localparam int unsigned ELEN_W = 11;

    // Multiplying by plain 1 converts a Montgomery-domain value back to the normal domain.
    localparam int unsigned MONT_ONE_OPERAND = 1;

    typedef enum logic [2:0] {
        StIdle,
        StNext,
        StSq,
        StSqW,
        StMul,
        StMulW,
        StPost,
        StPostW
    } state_e;

endpackage

// File: rtl/modexp_ctrl_if.sv
// Start/done handshake and operand bus between the exponentiation controller and the
// Montgomery multiplier.
interface modexp_ctrl_if
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned Width = WIDTH
) ();

    logic             mont_start;
    logic [Width-1:0] mont_a;
    logic [Width-1:0] mont_b;
    logic [Width-1:0] mont_m;
    logic [Width-1:0] mont_result;
    logic             mont_done;

    modport master (
        output mont_start,
        output mont_a,
        output mont_b,
        output mont_m,
        input  mont_result,
        input  mont_done
    );

    modport slave (
        input  mont_start,
        input  mont_a,
        input  mont_b,
        input  mont_m,
        output mont_result,
        output mont_done
    );

endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^e mod M with one external
// Montgomery multiplier; a final multiply by 1 leaves the Montgomery domain.
module modexp_ctrl
    import modexp_ctrl_pkg::*;
#(
    parameter int unsigned Width = WIDTH,
    parameter int unsigned ElenW = ELEN_W
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             start_i,
    input  logic [Width-1:0] in_x_i,
    input  logic [Width-1:0] in_r_i,
    input  logic [Width-1:0] in_e_i,
    input  logic [ElenW-1:0] in_elen_i,
    input  logic [Width-1:0] in_m_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] result_o,
    modexp_ctrl_if.master    mont
);

    localparam int unsigned IdxW = $clog2(Width);

    state_e state_q, state_d;

    logic [Width-1:0] x_q, x_d;
    logic [Width-1:0] e_q, e_d;
    logic [Width-1:0] m_q, m_d;
    logic [Width-1:0] acc_q, acc_d;
    logic [Width-1:0] result_q, result_d;
    logic [Width-1:0] mont_a_q, mont_a_d;
    logic [Width-1:0] mont_b_q, mont_b_d;
    logic [ElenW-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mont_start_q, mont_start_d;

    // idx_q is already decremented when examined, so it always addresses a valid bit.
    logic e_bit;
    assign e_bit = e_q[idx_q[IdxW-1:0]];

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        e_d          = e_q;
        m_d          = m_q;
        acc_d        = acc_q;
        result_d     = result_q;
        mont_a_d     = mont_a_q;
        mont_b_d     = mont_b_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        mont_start_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    x_d     = in_x_i;
                    e_d     = in_e_i;
                    m_d     = in_m_i;
                    acc_d   = in_r_i;
                    idx_d   = in_elen_i;
                    busy_d  = 1'b1;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q == '0) begin
                    state_d = StPost;
                end else begin
                    idx_d   = idx_q - ElenW'(1);
                    state_d = StSq;
                end
            end
            StSq: begin
                mont_a_d     = acc_q;
                mont_b_d     = acc_q;
                mont_start_d = 1'b1;
                state_d      = StSqW;
            end
            StSqW: begin
                if (mont.mont_done) begin
                    acc_d   = mont.mont_result;
                    state_d = e_bit ? StMul : StNext;
                end
            end
            StMul: begin
                mont_a_d     = acc_q;
                mont_b_d     = x_q;
                mont_start_d = 1'b1;
                state_d      = StMulW;
            end
            StMulW: begin
                if (mont.mont_done) begin
                    acc_d   = mont.mont_result;
                    state_d = StNext;
                end
            end
            StPost: begin
                mont_a_d     = acc_q;
                mont_b_d     = Width'(MONT_ONE_OPERAND);
                mont_start_d = 1'b1;
                state_d      = StPostW;
            end
            StPostW: begin
                if (mont.mont_done) begin
                    result_d = mont.mont_result;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q      <= StIdle;
            x_q          <= '0;
            e_q          <= '0;
            m_q          <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            mont_a_q     <= '0;
            mont_b_q     <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mont_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            e_q          <= e_d;
            m_q          <= m_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            mont_a_q     <= mont_a_d;
            mont_b_q     <= mont_b_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mont_start_q <= mont_start_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign result_o        = result_q;
    assign mont.mont_start = mont_start_q;
    assign mont.mont_a     = mont_a_q;
    assign mont.mont_b     = mont_b_q;
    assign mont.mont_m     = m_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural bit-serial Montgomery multiplier
// and an independent shift-and-add modular arithmetic golden model.
module tb_modexp_ctrl;
    import modexp_ctrl_pkg::*;

    localparam int unsigned W  = WIDTH;
    localparam int unsigned EW = ELEN_W;
    typedef logic [W-1:0] word_t;

    typedef struct {
        word_t       res;
        int          calls;
        logic [63:0] seq;
        bit          chk_seq;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    word_t         in_x = '0, in_r = '0, in_e = '0, in_m = '0;
    logic [EW-1:0] in_elen = '0;
    logic          busy, done;
    word_t         result;

    always #5 clk = ~clk;

    modexp_ctrl_if #(.Width(W)) mif ();

    modexp_ctrl #(.Width(W), .ElenW(EW)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .start_i  (start),
        .in_x_i   (in_x),
        .in_r_i   (in_r),
        .in_e_i   (in_e),
        .in_elen_i(in_elen),
        .in_m_i   (in_m),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .mont     (mif)
    );

    int    n_chk = 0;
    int    n_err = 0;
    int    n_done = 0;
    int    calls = 0;
    exp_t  exp_q[$];
    word_t op_x = '0;
    word_t modulus;
    word_t r_mod;

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- golden arithmetic ----------------
    function automatic word_t mod_add(input word_t a, input word_t b, input word_t m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[W-1:0];
    endfunction

    function automatic word_t mod_mul(input word_t a, input word_t b, input word_t m);
        word_t t = '0;
        for (int i = W - 1; i >= 0; i--) begin
            t = mod_add(t, t, m);
            if (b[i]) t = mod_add(t, a, m);
        end
        return t;
    endfunction

    function automatic word_t mod_pow(input word_t x, input word_t e, input int t, input word_t m);
        word_t r = word_t'(1);
        for (int i = t - 1; i >= 0; i--) begin
            r = mod_mul(r, r, m);
            if (e[i]) r = mod_mul(r, x, m);
        end
        return r;
    endfunction

    function automatic word_t calc_r_mod(input word_t m);
        word_t r = word_t'(1);
        for (int i = 0; i < W; i++) r = mod_add(r, r, m);
        return r;
    endfunction

    function automatic word_t mont_mul(input word_t a, input word_t b, input word_t m);
        logic [W+1:0] t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    // ---------------- behavioural multiplier ----------------
    logic  mdl_done = 1'b0, mdl_busy = 1'b0, inj_done = 1'b0;
    word_t mdl_res = '0, inj_res = '0, lat_a = '0, lat_b = '0, lat_m = '0;
    int    mdl_cnt = 0, lat_sel = 0;

    assign mif.mont_done   = mdl_done | inj_done;
    assign mif.mont_result = inj_done ? inj_res : mdl_res;

    always @(posedge clk) begin
        if (!resetn) begin
            mdl_busy <= 1'b0;
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
        end else begin
            mdl_done <= 1'b0;
            if (mif.mont_start) begin
                lat_a    <= mif.mont_a;
                lat_b    <= mif.mont_b;
                lat_m    <= mif.mont_m;
                mdl_busy <= 1'b1;
                mdl_cnt  <= 2 + (lat_sel % 3);
                lat_sel  <= lat_sel + 1;
            end else if (mdl_busy) begin
                if (mdl_cnt == 0) begin
                    mdl_done <= 1'b1;
                    mdl_res  <= mont_mul(lat_a, lat_b, lat_m);
                    mdl_busy <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    function automatic logic [1:0] classify(input word_t a, input word_t b);
        if (b == word_t'(1)) return 2'd3;
        if (a == b) return 2'd1;
        if (b == op_x) return 2'd2;
        return 2'd0;
    endfunction

    initial begin
        logic [63:0] seq;
        logic        prev_done;
        exp_t        it;
        seq       = '0;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                calls     = 0;
                seq       = '0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) chk("done_one_cycle", word_t'(done), '0);
                prev_done = 1'b0;
                if (mif.mont_start) begin
                    calls++;
                    seq = {seq[61:0], classify(mif.mont_a, mif.mont_b)};
                end
                if (mdl_done) begin
                    chk("operand_a_hold", mif.mont_a, lat_a);
                    chk("operand_b_hold", mif.mont_b, lat_b);
                    chk("operand_m_hold", mif.mont_m, modulus);
                end
                if (done) begin
                    n_done++;
                    prev_done = 1'b1;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_done: got done with result %0h, expected none", result);
                    end else begin
                        it = exp_q.pop_front();
                        chk({it.name, "_result"}, result, it.res);
                        chk({it.name, "_calls"}, word_t'(calls), word_t'(it.calls));
                        chk({it.name, "_busy_fall"}, word_t'(busy), '0);
                        if (it.chk_seq) chk({it.name, "_order"}, word_t'(seq), word_t'(it.seq));
                    end
                    calls = 0;
                    seq   = '0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input word_t xm, input word_t e, input int t, input word_t exp_res,
                         input int exp_calls, input logic [63:0] eseq, input bit cs,
                         input string name);
        exp_t it;
        it.res = exp_res;
        it.calls = exp_calls;
        it.seq = eseq;
        it.chk_seq = cs;
        it.name = name;
        exp_q.push_back(it);
        @(negedge clk);
        in_x    = xm;
        in_r    = r_mod;
        in_e    = e;
        in_m    = modulus;
        in_elen = EW'(t);
        op_x    = xm;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int base = n_done;
        int cyc = 0;
        while (n_done == base && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (n_done == base) begin
            n_err++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected one", name, cyc);
        end
    endtask

    initial begin
        word_t xr, xe, exp_c, exp_g, e_long, e_rand;
        int    cyc;

        modulus = {1'b1, 1018'b0, 5'd29};
        r_mod   = calc_r_mod(modulus);

        repeat (3) @(negedge clk);
        chk("rst_busy", word_t'(busy), '0);
        chk("rst_done", word_t'(done), '0);
        chk("rst_result", result, '0);
        chk("rst_mont_start", word_t'(mif.mont_start), '0);
        chk("rst_mont_a", mif.mont_a, '0);
        chk("rst_mont_b", mif.mont_b, '0);
        chk("rst_mont_m", mif.mont_m, '0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // x=2, e=3, t=2: S,M,S,M,POST
        issue(mod_mul(word_t'(2), r_mod, modulus), word_t'(3), 2, word_t'(8), 5,
              64'h19B, 1'b1, "x2_e3");
        wait_done("x2_e3");

        // Bits at and above t must be ignored.
        issue(mod_mul(word_t'(2), r_mod, modulus), '1, 2, word_t'(8), 5,
              64'h19B, 1'b1, "high_bits_ignored");
        wait_done("high_bits_ignored");

        // e=0b1011 with random x, plus a start pulse while busy.
        xr = '0;
        for (int k = 0; k < int'(W / 32); k++) xr[k*32 +: 32] = $urandom;
        xr[W-1] = 1'b0;
        exp_c = mod_pow(xr, word_t'(11), 4, modulus);
        issue(mod_mul(xr, r_mod, modulus), word_t'(11), 4, exp_c, 8, 64'h659B, 1'b1, "e1011");
        repeat (6) @(negedge clk);
        in_x    = ~xr;
        in_e    = '0;
        in_elen = '0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done("e1011");

        // t=0: POST only.
        e_rand = '0;
        for (int k = 0; k < int'(W / 32); k++) e_rand[k*32 +: 32] = $urandom;
        issue(mod_mul(word_t'(7), r_mod, modulus), e_rand, 0, word_t'(1), 1, 64'h3, 1'b1, "t0");
        wait_done("t0");

        // t=1, e=1: result is x itself.
        xe = word_t'(64'h1234_5678_9ABC);
        issue(mod_mul(xe, r_mod, modulus), word_t'(1), 1, xe, 3, 64'h1B, 1'b1, "t1_e1");
        wait_done("t1_e1");

        // Stray mont_done while idle must not disturb anything.
        @(negedge clk);
        inj_res  = ~xe;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_done_result", result, xe);
        chk("idle_done_busy", word_t'(busy), '0);

        // Full-width exponent, aborted by reset during the third call (a square).
        e_long = '0;
        e_long[W-1] = 1'b1;
        e_long[2] = 1'b1;
        e_long[0] = 1'b1;
        exp_g = mod_pow(word_t'(3), e_long, W, modulus);
        issue(mod_mul(word_t'(3), r_mod, modulus), e_long, W, exp_g, W + 4, '0, 1'b0, "abort");
        cyc = 0;
        while (calls < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_sq", word_t'(calls >= 3), word_t'(1));
        exp_q.delete();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_busy", word_t'(busy), '0);
        chk("abort_done", word_t'(done), '0);
        chk("abort_result", result, '0);
        chk("abort_mont_start", word_t'(mif.mont_start), '0);
        @(negedge clk);

        issue(mod_mul(word_t'(3), r_mod, modulus), e_long, W, exp_g, W + 4, '0, 1'b0, "t_width");
        wait_done("t_width");

        repeat (20) @(negedge clk);
        chk("queue_drained", word_t'(exp_q.size()), '0);
        chk("done_count", word_t'(n_done), word_t'(6));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
